// File: rtl/issue_unit_pkg.sv
// Shared constants for the issue path: unit codes, instruction field positions and helpers.
// Kept in one place so fetch, decode and the reservation stations agree on the encoding.
package issue_unit_pkg;

    localparam int REG_SIZE  = 6;
    localparam int WORD_SIZE = 32;
    localparam int INST_W    = 32;
    localparam int IMM_W     = 16;

    localparam int UNIT_MSB   = 31;
    localparam int UNIT_LSB   = 29;
    localparam int HASIMM_BIT = 28;
    localparam int REG1_LSB   = 22;
    localparam int REG2_LSB   = 16;
    localparam int REG3_LSB   = 10;

    localparam logic [2:0] UNIT_LW   = 3'b000;
    localparam logic [2:0] UNIT_SW   = 3'b001;
    localparam logic [2:0] UNIT_ADD  = 3'b010;
    localparam logic [2:0] UNIT_MUL  = 3'b011;
    localparam logic [2:0] UNIT_MV   = 3'b100;
    localparam logic [2:0] UNIT_HALT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BACKOFF,
        S_HALTING,
        S_HALTED
    } state_e;

    typedef struct packed {
        logic [2:0]           unit;
        logic                 hasimm;
        logic [REG_SIZE-1:0]  reg1;
        logic [REG_SIZE-1:0]  reg2;
        logic [REG_SIZE-1:0]  reg3;
        logic [WORD_SIZE-1:0] imm;
    } issue_fields_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/issue_decode.sv
// Pure combinational split of an instruction word into the RS issue fields.
// Opcodes 110/111 have no functional unit and are flagged illegal.
module issue_decode
    import issue_unit_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output issue_fields_t     fields,
    output logic              illegal
);

    always_comb begin
        fields.unit   = inst[UNIT_MSB:UNIT_LSB];
        fields.hasimm = inst[HASIMM_BIT];
        fields.reg1   = inst[REG1_LSB +: REG_SIZE];
        fields.reg2   = inst[REG2_LSB +: REG_SIZE];
        fields.reg3   = inst[REG3_LSB +: REG_SIZE];
        fields.imm    = {{(WORD_SIZE-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
        illegal       = (inst[UNIT_MSB -: 2] == 2'b11);
    end

endmodule

// File: rtl/issue_unit.sv
// In-order issuer: accepts one decoded instruction, strobes it into the RS, retries with
// backoff on "full", times out a silent RS, and sequences halt until the stations drain.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int BACKOFF      = 4,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_valid,
    input  logic [INST_W-1:0]    inst,
    output logic                 inst_ready,
    output logic [2:0]           unit,
    output logic [REG_SIZE-1:0]  reg1,
    output logic [REG_SIZE-1:0]  reg2,
    output logic [REG_SIZE-1:0]  reg3,
    output logic                 hasimm,
    output logic [WORD_SIZE-1:0] imm,
    output logic                 enable,
    input  logic                 rs_done,
    input  logic                 rs_out,
    input  logic                 rs_idle,
    output logic                 halted,
    output logic                 err,
    output logic [15:0]          issue_cnt,
    output logic [15:0]          stall_cnt
);

    localparam int BO_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam int TO_W = $clog2(WAIT_TIMEOUT);

    state_e        state_reg;
    issue_fields_t fields_reg;
    issue_fields_t dec_fields;
    logic          dec_illegal;
    logic [BO_W-1:0] bo_cnt_reg;
    logic [TO_W-1:0] to_cnt_reg;

    issue_decode u_decode (
        .inst    (inst),
        .fields  (dec_fields),
        .illegal (dec_illegal)
    );

    assign unit   = fields_reg.unit;
    assign hasimm = fields_reg.hasimm;
    assign reg1   = fields_reg.reg1;
    assign reg2   = fields_reg.reg2;
    assign reg3   = fields_reg.reg3;
    assign imm    = fields_reg.imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            fields_reg <= '0;
            bo_cnt_reg <= '0;
            to_cnt_reg <= '0;
            enable     <= 1'b0;
            inst_ready <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
            issue_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            enable <= 1'b0;
            err    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    inst_ready <= 1'b1;
                    if (inst_valid && inst_ready) begin
                        // Illegal words are swallowed: stay ready, flag err, issue nothing.
                        if (dec_illegal) begin
                            err <= 1'b1;
                        end else begin
                            fields_reg <= dec_fields;
                            enable     <= 1'b1;
                            inst_ready <= 1'b0;
                            state_reg  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt_reg <= '0;
                    state_reg  <= S_WAIT;
                end
                S_WAIT: begin
                    // A reply in the expiry cycle still counts, so rs_done is tested first.
                    if (rs_done) begin
                        if (rs_out) begin
                            issue_cnt <= sat_inc(issue_cnt);
                            if (fields_reg.unit == UNIT_HALT) begin
                                state_reg <= S_HALTING;
                            end else begin
                                inst_ready <= 1'b1;
                                state_reg  <= S_IDLE;
                            end
                        end else begin
                            stall_cnt  <= sat_inc(stall_cnt);
                            bo_cnt_reg <= BO_W'(BACKOFF - 1);
                            state_reg  <= S_BACKOFF;
                        end
                    end else if (to_cnt_reg == TO_W'(WAIT_TIMEOUT - 1)) begin
                        err        <= 1'b1;
                        inst_ready <= 1'b1;
                        state_reg  <= S_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    if (bo_cnt_reg == '0) begin
                        enable    <= 1'b1;
                        state_reg <= S_ISSUE;
                    end else begin
                        bo_cnt_reg <= bo_cnt_reg - 1'b1;
                    end
                end
                S_HALTING: begin
                    if (rs_idle) begin
                        halted    <= 1'b1;
                        state_reg <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    inst_ready <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Directed + randomized bench for issue_unit: the bench plays fetch queue and RS and
// predicts fields, strobe timing and counters from the instruction-level behaviour.
module tb_issue_unit;

    localparam int BACKOFF      = 4;
    localparam int WAIT_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_ready;
    logic [2:0]  unit;
    logic [5:0]  reg1, reg2, reg3;
    logic        hasimm;
    logic [31:0] imm;
    logic        enable;
    logic        rs_done = 1'b0;
    logic        rs_out = 1'b0;
    logic        rs_idle = 1'b0;
    logic        halted;
    logic        err;
    logic [15:0] issue_cnt, stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_issue = 0;
    int exp_stall = 0;

    issue_unit #(.BACKOFF(BACKOFF), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_ready (inst_ready),
        .unit       (unit),
        .reg1       (reg1),
        .reg2       (reg2),
        .reg3       (reg3),
        .hasimm     (hasimm),
        .imm        (imm),
        .enable     (enable),
        .rs_done    (rs_done),
        .rs_out     (rs_out),
        .rs_idle    (rs_idle),
        .halted     (halted),
        .err        (err),
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] sext16(input logic [31:0] w);
        logic [31:0] r;
        r = {16'h0000, w[15:0]};
        if (w[15]) r[31:16] = 16'hFFFF;
        return r;
    endfunction

    task automatic check_fields(input string tag, input logic [31:0] w);
        chk({tag, "_unit"},   {29'd0, unit},   {29'd0, w[31:29]});
        chk({tag, "_hasimm"}, {31'd0, hasimm}, {31'd0, w[28]});
        chk({tag, "_reg1"},   {26'd0, reg1},   {26'd0, w[27:22]});
        chk({tag, "_reg2"},   {26'd0, reg2},   {26'd0, w[21:16]});
        chk({tag, "_reg3"},   {26'd0, reg3},   {26'd0, w[15:10]});
        chk({tag, "_imm"},    imm,             sext16(w));
    endtask

    // Present a word until accepted; returns in the cycle right after the handshake edge.
    task automatic send(input logic [31:0] w);
        int n;
        inst       = w;
        inst_valid = 1'b1;
        n = 0;
        while (!inst_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_bound", {31'd0, inst_ready}, 32'd1);
        step();
        inst_valid = 1'b0;
        inst       = $urandom;
    endtask

    // One legal instruction: `fulls` full replies, then an accept; each reply after `delay` idle WAIT cycles.
    task automatic issue_txn(input logic [31:0] w, input int fulls, input int delay);
        send(w);
        chk("enable_latency", {31'd0, enable}, 32'd1);
        check_fields("issue", w);
        for (int k = 0; k <= fulls; k++) begin
            step();
            for (int d = 0; d < delay; d++) begin
                rs_out = $urandom_range(0, 1);
                step();
            end
            rs_done = 1'b1;
            rs_out  = (k == fulls);
            step();
            rs_done = 1'b0;
            rs_out  = $urandom_range(0, 1);
            if (k < fulls) begin
                exp_stall++;
                for (int b = 0; b < BACKOFF; b++) begin
                    chk("backoff_quiet", {31'd0, enable}, 32'd0);
                    step();
                end
                chk("reissue_enable", {31'd0, enable}, 32'd1);
                check_fields("reissue", w);
            end else begin
                exp_issue++;
            end
        end
        chk("no_err_after_reply", {31'd0, err}, 32'd0);
        chk("issue_cnt", {16'd0, issue_cnt}, exp_issue);
        chk("stall_cnt", {16'd0, stall_cnt}, exp_stall);
        if (w[31:29] != 3'b101)
            chk("ready_after_accept", {31'd0, inst_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_word(input logic [2:0] op);
        logic [31:0] w;
        w = $urandom;
        w[31:29] = op;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        bit seen;
        int op;

        // Reset state
        rst_n = 1'b0;
        #2;
        chk("rst_enable", {31'd0, enable}, 32'd0);
        step();
        step();
        chk("rst_ready",  {31'd0, inst_ready}, 32'd0);
        chk("rst_halted", {31'd0, halted},     32'd0);
        chk("rst_err",    {31'd0, err},        32'd0);
        chk("rst_issue",  {16'd0, issue_cnt},  32'd0);
        chk("rst_stall",  {16'd0, stall_cnt},  32'd0);
        chk("rst_reg1",   {26'd0, reg1},       32'd0);
        chk("rst_imm",    imm,                 32'd0);
        rst_n = 1'b1;
        step();

        // add r3,r1,r2 accepted first time
        w = {3'b010, 1'b0, 6'd3, 6'd1, 6'd2, 10'd0};
        issue_txn(w, 0, 0);

        // lw with negative imm, two full replies then accept
        w = {3'b000, 1'b1, 6'd5, 6'd7, 16'hFFFC};
        issue_txn(w, 2, 0);
        chk("lw_imm_sext", imm, 32'hFFFF_FFFC);

        // Illegal opcode 111
        send(rand_word(3'b111));
        chk("illegal_err",    {31'd0, err},    32'd1);
        chk("illegal_enable", {31'd0, enable}, 32'd0);
        step();
        chk("illegal_err_clr",  {31'd0, err},        32'd0);
        chk("illegal_no_issue", {31'd0, enable},     32'd0);
        chk("illegal_ready",    {31'd0, inst_ready}, 32'd1);

        // WAIT timeout
        send(rand_word(3'b011));
        chk("to_enable", {31'd0, enable}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < WAIT_TIMEOUT; i++) begin
            step();
            if (err || enable) seen = 1'b1;
        end
        chk("to_not_early", {31'd0, seen}, 32'd0);
        step();
        chk("to_err",   {31'd0, err},       32'd1);
        chk("to_issue", {16'd0, issue_cnt}, exp_issue);
        step();
        chk("to_err_pulse", {31'd0, err},        32'd0);
        chk("to_ready",     {31'd0, inst_ready}, 32'd1);

        // Reply landing in the expiry cycle wins over the timeout
        issue_txn(rand_word(3'b001), 0, WAIT_TIMEOUT - 1);

        // Randomized traffic, with stray rs_done strobes while idle
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                rs_done = 1'b1;
                rs_out  = $urandom_range(0, 1);
                step();
                rs_done = 1'b0;
            end
            op = $urandom_range(0, 5);
            if (op == 5) begin
                send(rand_word($urandom_range(0, 1) ? 3'b110 : 3'b111));
                chk("rand_illegal_err", {31'd0, err}, 32'd1);
                step();
            end else begin
                issue_txn(rand_word(3'(op)), $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end

        // Reset asserted during BACKOFF
        send(rand_word(3'b010));
        step();
        rs_done = 1'b1;
        rs_out  = 1'b0;
        step();
        rs_done = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_issue = 0;
        exp_stall = 0;
        chk("arst_enable", {31'd0, enable},     32'd0);
        chk("arst_ready",  {31'd0, inst_ready}, 32'd0);
        chk("arst_stall",  {16'd0, stall_cnt},  32'd0);
        chk("arst_issue",  {16'd0, issue_cnt},  32'd0);
        chk("arst_reg1",   {26'd0, reg1},       32'd0);
        chk("arst_imm",    imm,                 32'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (enable) seen = 1'b1;
        end
        chk("arst_no_ghost", {31'd0, seen}, 32'd0);
        issue_txn(rand_word(3'b100), 1, 1);

        // Halt: one full reply, then drain
        rs_idle = 1'b0;
        issue_txn(rand_word(3'b101), 1, 0);
        inst       = rand_word(3'b010);
        inst_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (inst_ready || halted || enable) seen = 1'b1;
            step();
        end
        chk("halting_blocked", {31'd0, seen}, 32'd0);
        rs_idle = 1'b1;
        step();
        chk("halted_rise", {31'd0, halted}, 32'd1);
        rs_idle = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!halted || inst_ready || enable) seen = 1'b1;
        end
        chk("halted_sticky", {31'd0, seen}, 32'd0);
        chk("halt_issue_cnt", {16'd0, issue_cnt}, exp_issue);
        inst_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
